// File: rtl/sd_pkg.sv
// Shared types and constants for the SD DAT0 write path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SBIT,
        ST_DATA,
        ST_CRC,
        ST_EBIT,
        ST_TURN,
        ST_SWAIT,
        ST_STOK,
        ST_BUSYW,
        ST_FIN
    } state_t;

    // Completion codes reported on ERR
    localparam logic [2:0] ERR_OK    = 3'd0;
    localparam logic [2:0] ERR_CRC   = 3'd1;
    localparam logic [2:0] ERR_WR    = 3'd2;
    localparam logic [2:0] ERR_STAT  = 3'd3;
    localparam logic [2:0] ERR_BUSY  = 3'd4;
    localparam logic [2:0] ERR_UNDER = 3'd5;

    // x^16 + x^12 + x^5 + 1
    localparam logic [15:0] CRC16_POLY = 16'h1021;

    // CRC-status token bits returned by the card
    localparam logic [2:0] TOK_OK  = 3'b010;
    localparam logic [2:0] TOK_CRC = 3'b101;
    localparam logic [2:0] TOK_WR  = 3'b110;

    // Map a captured status token plus its end bit to a completion code.
    // A good token only counts when framed by a proper end bit.
    function automatic logic [2:0] tok_to_err(input logic [2:0] tok, input logic end_bit);
        if (tok == TOK_OK && end_bit) return ERR_OK;
        else if (tok == TOK_CRC)      return ERR_CRC;
        else if (tok == TOK_WR)       return ERR_WR;
        else                          return ERR_STAT;
    endfunction

endpackage

// File: rtl/sd_data_write_ctrl_if.sv
// Handshake/pad bundle between host FSM, byte source, DAT0 pad and the write controller.
// Latency: n/a (wires only).
// Backpressure: DIN_VALID/DIN_READY on the byte source; START is ignored while BUSY.
// Ports: START/DONE/ERR/BUSY (host), DIN/DIN_VALID/DIN_READY (byte source),
//        DAT_OUT/DAT_OE/DAT_IN (DAT0 pad).
interface sd_data_write_ctrl_if;
    logic       START;
    logic [7:0] DIN;
    logic       DIN_VALID;
    logic       DIN_READY;
    logic       DAT_OUT;
    logic       DAT_OE;
    logic       DAT_IN;
    logic       BUSY;
    logic       DONE;
    logic [2:0] ERR;

    modport master (
        output START, DIN, DIN_VALID, DAT_IN,
        input  DIN_READY, DAT_OUT, DAT_OE, BUSY, DONE, ERR
    );

    modport slave (
        input  START, DIN, DIN_VALID, DAT_IN,
        output DIN_READY, DAT_OUT, DAT_OE, BUSY, DONE, ERR
    );
endinterface

// File: rtl/sd_crc16_serial.sv
// Bit-serial CRC16 LFSR (MSB-first, init 0), shared by the DAT read and write paths.
// Latency: CRC reflects BIT_IN one CLK after EN.
// Backpressure: none; advances only when EN=1, CLR has priority.
// Ports: CLK, RST (async active-low), CLR, EN, BIT_IN, CRC[15:0].
module sd_crc16_serial
    import sd_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        CLR,
    input  logic        EN,
    input  logic        BIT_IN,
    output logic [15:0] CRC
);

    logic fb;

    assign fb = BIT_IN ^ CRC[15];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            CRC <= '0;
        end else if (CLR) begin
            CRC <= '0;
        end else if (EN) begin
            CRC <= {CRC[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/sd_data_write_ctrl.sv
// Single-block SD write on DAT0: start bit, payload, CRC16, end bit, status token, busy wait.
// Latency: 1 + 8*BLOCK_BYTES + 16 + 1 + 2 CLKs on the wire, then card-paced token/busy, DONE one CLK later.
// Backpressure: pulls bytes via DIN_VALID/DIN_READY; a missing byte aborts with ERR=5 (no stall).
// Ports: CLK, RST (async active-low), bus (slave modport: START/DONE/ERR/BUSY, DIN*, DAT_*).
module sd_data_write_ctrl
    import sd_pkg::*;
#(
    parameter int BLOCK_BYTES = 512,
    parameter int NWR_MAX     = 16,
    parameter int BUSY_MAX    = 65535
) (
    input  logic                  CLK,
    input  logic                  RST,
    sd_data_write_ctrl_if.slave   bus
);

    localparam int              BCW       = $clog2(BLOCK_BYTES + 1);
    localparam logic [BCW-1:0]  LAST_BYTE = BCW'(BLOCK_BYTES - 1);
    localparam logic [15:0]     NWR_LAST  = 16'(NWR_MAX - 1);
    localparam logic [15:0]     BUSY_LAST = 16'(BUSY_MAX - 1);

    state_t         state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_q, bit_d;
    logic [BCW-1:0] byte_q, byte_d;
    logic [15:0]    wcnt_q, wcnt_d;
    logic [2:0]     tok_q, tok_d;
    logic [2:0]     err_q, err_d;

    logic           crc_clr, crc_en, crc_bit;
    logic [15:0]    crc;

    // While sending the remainder the LFSR is fed its own MSB: the feedback
    // term cancels, so the register simply shifts the remainder out MSB-first.
    sd_crc16_serial u_crc (
        .CLK    (CLK),
        .RST    (RST),
        .CLR    (crc_clr),
        .EN     (crc_en),
        .BIT_IN (crc_bit),
        .CRC    (crc)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            wcnt_q  <= '0;
            tok_q   <= '0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            wcnt_q  <= wcnt_d;
            tok_q   <= tok_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_d         = bit_q;
        byte_d        = byte_q;
        wcnt_d        = (wcnt_q == 16'hFFFF) ? wcnt_q : wcnt_q + 16'd1;
        tok_d         = tok_q;
        err_d         = err_q;
        crc_clr       = 1'b0;
        crc_en        = 1'b0;
        crc_bit       = shift_q[7];
        bus.DIN_READY = 1'b0;
        bus.DAT_OUT   = 1'b1;
        bus.DAT_OE    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                wcnt_d = '0;
                if (bus.START) begin
                    state_d = ST_SBIT;
                    err_d   = ERR_OK;
                    crc_clr = 1'b1;
                end
            end
            ST_SBIT: begin
                bus.DAT_OE    = 1'b1;
                bus.DAT_OUT   = 1'b0;
                bus.DIN_READY = 1'b1;
                bit_d         = '0;
                byte_d        = '0;
                if (bus.DIN_VALID) begin
                    shift_d = bus.DIN;
                    state_d = ST_DATA;
                end else begin
                    err_d   = ERR_UNDER;
                    state_d = ST_FIN;
                end
            end
            ST_DATA: begin
                bus.DAT_OE  = 1'b1;
                bus.DAT_OUT = shift_q[7];
                crc_en      = 1'b1;
                bit_d       = bit_q + 3'd1;
                shift_d     = {shift_q[6:0], 1'b0};
                // Next byte is fetched while its predecessor's LSB is on the wire
                if (bit_q == 3'd7) begin
                    if (byte_q == LAST_BYTE) begin
                        state_d = ST_CRC;
                        wcnt_d  = '0;
                    end else begin
                        bus.DIN_READY = 1'b1;
                        if (bus.DIN_VALID) begin
                            shift_d = bus.DIN;
                            byte_d  = byte_q + BCW'(1);
                        end else begin
                            err_d   = ERR_UNDER;
                            state_d = ST_FIN;
                        end
                    end
                end
            end
            ST_CRC: begin
                bus.DAT_OE  = 1'b1;
                bus.DAT_OUT = crc[15];
                crc_en      = 1'b1;
                crc_bit     = crc[15];
                if (wcnt_q == 16'd15) state_d = ST_EBIT;
            end
            ST_EBIT: begin
                bus.DAT_OE = 1'b1;
                state_d    = ST_TURN;
                wcnt_d     = '0;
            end
            ST_TURN: begin
                if (wcnt_q == 16'd1) begin
                    state_d = ST_SWAIT;
                    wcnt_d  = '0;
                end
            end
            ST_SWAIT: begin
                if (!bus.DAT_IN) begin
                    state_d = ST_STOK;
                    wcnt_d  = '0;
                end else if (wcnt_q == NWR_LAST) begin
                    err_d   = ERR_STAT;
                    state_d = ST_FIN;
                end
            end
            ST_STOK: begin
                if (wcnt_q < 16'd3) begin
                    tok_d = {tok_q[1:0], bus.DAT_IN};
                end else begin
                    err_d   = tok_to_err(tok_q, bus.DAT_IN);
                    state_d = ST_BUSYW;
                    wcnt_d  = '0;
                end
            end
            ST_BUSYW: begin
                if (bus.DAT_IN) begin
                    state_d = ST_FIN;
                end else if (wcnt_q == BUSY_LAST) begin
                    err_d   = ERR_BUSY;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.BUSY = (state_q != ST_IDLE);
    assign bus.DONE = (state_q == ST_FIN);
    assign bus.ERR  = err_q;

endmodule

// File: tb/tb_sd_data_write_ctrl.sv
module tb_sd_data_write_ctrl;
    import sd_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 CLK = ~CLK;

    sd_data_write_ctrl_if ba ();
    sd_data_write_ctrl_if bb ();

    sd_data_write_ctrl #(.BLOCK_BYTES(4), .NWR_MAX(16), .BUSY_MAX(40)) dut_a (
        .CLK (CLK),
        .RST (RST),
        .bus (ba)
    );

    sd_data_write_ctrl #(.BLOCK_BYTES(512), .NWR_MAX(16), .BUSY_MAX(40)) dut_b (
        .CLK (CLK),
        .RST (RST),
        .bus (bb)
    );

    // Drives one 4-byte transfer on dut_a and plays the card. Cycle c=0 is the SBIT cycle.
    // drop_at: byte index whose DIN_VALID is withheld (-1 none). nwr: SWAIT cycles before the
    // token start bit (-1 never). tok: {start,b2,b1,b0,end}. busy: low cycles after token (-1 forever).
    task automatic run_a(input logic [31:0] payload, input int drop_at, input int nwr,
                         input logic [4:0] tok, input int busy,
                         output logic [63:0] frame, output int nbits, output int done_c,
                         output logic [2:0] err_o, output logic busy0, output logic [2:0] err0);
        int idx = 0;
        bit acc = 0;
        int t   = -1;
        int k;
        frame = '0; nbits = 0; done_c = -1; err_o = 3'b111; busy0 = 1'b0; err0 = 3'b111;
        @(negedge CLK);
        ba.START     = 1'b1;
        ba.DAT_IN    = 1'b1;
        ba.DIN       = payload[31:24];
        ba.DIN_VALID = (drop_at != 0);
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            ba.START = 1'b0;
            if (c == 0) begin busy0 = ba.BUSY; err0 = ba.ERR; end
            if (acc) idx++;
            ba.DIN       = (idx < 4) ? 8'(payload >> (8 * (3 - idx))) : 8'h00;
            ba.DIN_VALID = (idx != drop_at);
            acc          = ba.DIN_READY && ba.DIN_VALID;
            if (ba.DAT_OE) begin
                frame = {frame[62:0], ba.DAT_OUT};
                nbits++;
            end else if (nbits > 0) begin
                t++;
            end
            k = t - 2 - nwr;
            if (nwr < 0 || t < 0 || k < 0)        ba.DAT_IN = 1'b1;
            else if (k < 5)                       ba.DAT_IN = tok[4-k];
            else if (busy < 0 || k < 5 + busy)    ba.DAT_IN = 1'b0;
            else                                  ba.DAT_IN = 1'b1;
            if (ba.DONE) begin
                done_c = c;
                err_o  = ba.ERR;
                break;
            end
        end
        ba.DAT_IN = 1'b1;
    endtask

    task automatic test_reset;
        logic [7:0] va, vb;
        va = {ba.DAT_OUT, ba.DAT_OE, ba.BUSY, ba.DONE, ba.DIN_READY, ba.ERR};
        vb = {bb.DAT_OUT, bb.DAT_OE, bb.BUSY, bb.DONE, bb.DIN_READY, bb.ERR};
        n_chk++; if (va !== 8'h80) $display("FAIL reset_a got %h expected 80", va); else n_pass++;
        n_chk++; if (vb !== 8'h80) $display("FAIL reset_b got %h expected 80", vb); else n_pass++;
    endtask

    task automatic test_basic_write;
        logic [63:0] fr; int nb, dc; logic [2:0] er, e0; logic b0;
        run_a(32'h00FFA53C, -1, 0, 5'b0_010_1, 10, fr, nb, dc, er, b0, e0);
        n_chk++; if (b0 !== 1'b1) $display("FAIL basic_busy got %b expected 1", b0); else n_pass++;
        n_chk++; if (nb !== 50) $display("FAIL basic_nbits got %0d expected 50", nb); else n_pass++;
        n_chk++; if (fr[49:0] !== {1'b0, 32'h00FFA53C, 16'hDA37, 1'b1})
            $display("FAIL basic_frame got %h expected %h", fr[49:0], {1'b0, 32'h00FFA53C, 16'hDA37, 1'b1});
        else n_pass++;
        n_chk++; if (dc !== 68) $display("FAIL basic_done got %0d expected 68", dc); else n_pass++;
        n_chk++; if (er !== ERR_OK) $display("FAIL basic_err got %0d expected 0", er); else n_pass++;
    endtask

    task automatic test_token_errors;
        logic [63:0] fr; int nb, dc; logic [2:0] er, e0; logic b0;
        run_a(32'h12345678, -1, 0, 5'b0_110_1, 3, fr, nb, dc, er, b0, e0);
        n_chk++; if (dc !== 61) $display("FAIL tok110_done got %0d expected 61", dc); else n_pass++;
        n_chk++; if (er !== ERR_WR) $display("FAIL tok110_err got %0d expected 2", er); else n_pass++;
        run_a(32'h12345678, -1, 0, 5'b0_011_1, 3, fr, nb, dc, er, b0, e0);
        n_chk++; if (er !== ERR_STAT) $display("FAIL tok011_err got %0d expected 3", er); else n_pass++;
        run_a(32'h12345678, -1, 3, 5'b0_010_0, 3, fr, nb, dc, er, b0, e0);
        n_chk++; if (dc !== 64) $display("FAIL tok010_noend_done got %0d expected 64", dc); else n_pass++;
        n_chk++; if (er !== ERR_STAT) $display("FAIL tok010_noend_err got %0d expected 3", er); else n_pass++;
    endtask

    task automatic test_nwr_timeout;
        logic [63:0] fr; int nb, dc; logic [2:0] er, e0; logic b0;
        run_a(32'h00FFA53C, -1, -1, 5'b0_010_1, 0, fr, nb, dc, er, b0, e0);
        n_chk++; if (dc !== 68) $display("FAIL nwr_done got %0d expected 68", dc); else n_pass++;
        n_chk++; if (er !== ERR_STAT) $display("FAIL nwr_err got %0d expected 3", er); else n_pass++;
        @(negedge CLK);
        n_chk++; if ({ba.DONE, ba.BUSY} !== 2'b00)
            $display("FAIL nwr_after_done got %b expected 00", {ba.DONE, ba.BUSY});
        else n_pass++;
        n_chk++; if (ba.ERR !== ERR_STAT) $display("FAIL nwr_err_held got %0d expected 3", ba.ERR); else n_pass++;
    endtask

    task automatic test_busy_timeout;
        logic [63:0] fr; int nb, dc; logic [2:0] er, e0; logic b0;
        run_a(32'hCAFEBABE, -1, 0, 5'b0_010_1, -1, fr, nb, dc, er, b0, e0);
        n_chk++; if (dc !== 97) $display("FAIL busyto_done got %0d expected 97", dc); else n_pass++;
        n_chk++; if (er !== ERR_BUSY) $display("FAIL busyto_err got %0d expected 4", er); else n_pass++;
        run_a(32'hCAFEBABE, -1, 0, 5'b0_101_1, -1, fr, nb, dc, er, b0, e0);
        n_chk++; if (er !== ERR_BUSY) $display("FAIL busyto_override got %0d expected 4", er); else n_pass++;
    endtask

    task automatic test_underrun;
        logic [63:0] fr; int nb, dc; logic [2:0] er, e0; logic b0;
        run_a(32'h12345678, 2, -1, 5'b0_010_1, 0, fr, nb, dc, er, b0, e0);
        n_chk++; if (nb !== 17) $display("FAIL under2_nbits got %0d expected 17", nb); else n_pass++;
        n_chk++; if (fr[16:0] !== {1'b0, 16'h1234})
            $display("FAIL under2_frame got %h expected %h", fr[16:0], {1'b0, 16'h1234});
        else n_pass++;
        n_chk++; if (dc !== 17) $display("FAIL under2_done got %0d expected 17", dc); else n_pass++;
        n_chk++; if (er !== ERR_UNDER) $display("FAIL under2_err got %0d expected 5", er); else n_pass++;
        run_a(32'h12345678, 0, -1, 5'b0_010_1, 0, fr, nb, dc, er, b0, e0);
        n_chk++; if ({nb, dc} !== {32'd1, 32'd1})
            $display("FAIL under0_nbits_done got %0d/%0d expected 1/1", nb, dc);
        else n_pass++;
        n_chk++; if (er !== ERR_UNDER) $display("FAIL under0_err got %0d expected 5", er); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [63:0] fr; int nb, dc; logic [2:0] er, e0; logic b0;
        run_a(32'h12345678, 1, -1, 5'b0_010_1, 0, fr, nb, dc, er, b0, e0);
        // START coinciding with DONE must not launch a transfer
        ba.START = 1'b1;
        @(negedge CLK);
        ba.START = 1'b0;
        n_chk++; if (ba.BUSY !== 1'b0) $display("FAIL b2b_start_at_done got %b expected 0", ba.BUSY); else n_pass++;
        @(negedge CLK);
        n_chk++; if (ba.BUSY !== 1'b0) $display("FAIL b2b_no_queue got %b expected 0", ba.BUSY); else n_pass++;
        n_chk++; if (ba.ERR !== ERR_UNDER) $display("FAIL b2b_err_held got %0d expected 5", ba.ERR); else n_pass++;
        run_a(32'h00FFA53C, -1, 0, 5'b0_010_1, 10, fr, nb, dc, er, b0, e0);
        n_chk++; if (e0 !== ERR_OK) $display("FAIL b2b_err_cleared got %0d expected 0", e0); else n_pass++;
        n_chk++; if ({dc, 29'd0, er} !== {32'd68, 32'd0})
            $display("FAIL b2b_second got done %0d err %0d expected 68/0", dc, er);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int bad = 0;
        @(negedge CLK);
        ba.START = 1'b1; ba.DIN = 8'hA5; ba.DIN_VALID = 1'b1; ba.DAT_IN = 1'b1;
        @(negedge CLK);
        ba.START = 1'b0;
        repeat (4) @(negedge CLK);
        n_chk++; if ({ba.BUSY, ba.DAT_OE, ba.DAT_OUT} !== 3'b110)
            $display("FAIL mid_data4 got %b expected 110", {ba.BUSY, ba.DAT_OE, ba.DAT_OUT});
        else n_pass++;
        ba.START = 1'b1;
        @(negedge CLK);
        ba.START = 1'b0;
        @(negedge CLK);
        n_chk++; if ({ba.BUSY, ba.DAT_OE, ba.DAT_OUT} !== 3'b111)
            $display("FAIL mid_start_ignored got %b expected 111", {ba.BUSY, ba.DAT_OE, ba.DAT_OUT});
        else n_pass++;
        RST = 1'b0;
        #1;
        n_chk++; if ({ba.BUSY, ba.DAT_OE, ba.DAT_OUT, ba.DONE} !== 4'b0010)
            $display("FAIL mid_async_reset got %b expected 0010", {ba.BUSY, ba.DAT_OE, ba.DAT_OUT, ba.DONE});
        else n_pass++;
        @(negedge CLK);
        RST = 1'b1;
        repeat (6) begin
            @(negedge CLK);
            if (ba.DONE || ba.BUSY) bad++;
        end
        n_chk++; if (bad !== 0) $display("FAIL mid_idle_after got %0d busy/done cycles expected 0", bad); else n_pass++;
    endtask

    task automatic test_full_block;
        logic [63:0] frame = '0;
        int nbits = 0, t = -1, k, done_c = -1;
        logic [2:0] err = 3'b111;
        logic [4:0] tok = 5'b0_101_1;
        @(negedge CLK);
        bb.START = 1'b1; bb.DIN = 8'hFF; bb.DIN_VALID = 1'b1; bb.DAT_IN = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            @(negedge CLK);
            bb.START = 1'b0;
            if (bb.DAT_OE) begin
                frame = {frame[62:0], bb.DAT_OUT};
                nbits++;
            end else if (nbits > 0) begin
                t++;
            end
            k = t - 2;
            if (t < 0 || k < 0) bb.DAT_IN = 1'b1;
            else if (k < 5)     bb.DAT_IN = tok[4-k];
            else if (k < 10)    bb.DAT_IN = 1'b0;
            else                bb.DAT_IN = 1'b1;
            if (bb.DONE) begin
                done_c = c;
                err    = bb.ERR;
                break;
            end
        end
        bb.DAT_IN = 1'b1;
        n_chk++; if (nbits !== 4114) $display("FAIL blk512_nbits got %0d expected 4114", nbits); else n_pass++;
        n_chk++; if (frame[16:0] !== {16'h7FA1, 1'b1})
            $display("FAIL blk512_crc got %h expected %h", frame[16:0], {16'h7FA1, 1'b1});
        else n_pass++;
        n_chk++; if (done_c !== 4127) $display("FAIL blk512_done got %0d expected 4127", done_c); else n_pass++;
        n_chk++; if (err !== ERR_CRC) $display("FAIL blk512_err got %0d expected 1", err); else n_pass++;
    endtask

    initial begin
        ba.START = 1'b0; ba.DIN = 8'h00; ba.DIN_VALID = 1'b0; ba.DAT_IN = 1'b1;
        bb.START = 1'b0; bb.DIN = 8'h00; bb.DIN_VALID = 1'b0; bb.DAT_IN = 1'b1;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        test_reset();
        RST = 1'b1;
        test_basic_write();
        test_token_errors();
        test_nwr_timeout();
        test_busy_timeout();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
        test_full_block();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
